// File: rtl/cim_bitserial_ctrl_pkg.sv
// Shared types, default sizes and the macro address helper for the CIM bit-serial sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   cim_state_t    - sequencer FSM states
//   CIM_* consts   - default parameter values and row/column counts
//   cim_addr()     - composes the macro address from row group and column sub-select
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cim_state_t;

    localparam int CIM_ADDR_WIDTH      = 10;
    localparam int CIM_ACT_WIDTH       = 8;
    localparam int CIM_INPUT_PRECISION = 4;
    localparam int CIM_ADC_PRECISION   = 6;
    localparam int CIM_ACC_WIDTH       = 16;
    localparam int CIM_NUM_ROWS        = 4;
    localparam int CIM_NUM_COLS        = 8;

    // Row group sits in address bits [7:5] and the column sub-select in bits [1:0].
    function automatic logic [CIM_ADDR_WIDTH-1:0] cim_addr(input logic [2:0] rg,
                                                           input logic [1:0] col);
        return {2'b00, rg, 3'b000, col};
    endfunction

endpackage

// File: rtl/cim_bitserial_ctrl_col_acc.sv
// Single-column accumulator: clear, or add an ADC result shifted to its slice weight.
// Latency: result visible one clk after clr/en.
// Backpressure: none; the sequencer decides when to clear and when to add.
//
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   clr      - zero the sum (takes priority over en)
//   en       - add (res << shamt) to the sum
//   shamt    - shift amount, slice index times slice width
//   res      - unsigned ADC result for this column
//   acc      - running sum
module cim_col_acc #(
    parameter int ADC_PRECISION = 6,
    parameter int ACC_WIDTH     = 16,
    parameter int SHW           = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [SHW-1:0]           shamt,
    input  logic [ADC_PRECISION-1:0] res,
    output logic [ACC_WIDTH-1:0]     acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + (ACC_WIDTH'(res) << shamt);
        end
    end

endmodule

// File: rtl/cim_bitserial_ctrl.sv
// Bit-serial CIM sequencer: slices 4 activations, issues one macro read per slice, shift-accumulates 8 columns.
// Latency: out_valid rises 2*NSLICE clk after acceptance (fewer with zero-slice skipping).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Optional build macro: CIM_ZERO_SKIP_EN - slices that are zero on all four rows are skipped
// with no macro access; an all-zero vector completes one clk after acceptance.
//
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   in_valid/in_ready       - activation vector handshake
//   in_act0..3, in_rg, in_col - activations per weight row, row group, column sub-select
//   cim_cs/web/cimeb/a      - macro control and address (registered)
//   cim_in0..3              - current activation slice per row (registered)
//   cim_res0..7             - macro ADC results, valid in the CAPTURE cycle
//   out_valid/out_ready     - result handshake
//   out_acc0..7             - accumulated column sums
module cim_bitserial_ctrl
    import cim_pkg::*;
#(
    parameter int ADDR_WIDTH          = CIM_ADDR_WIDTH,
    parameter int ACT_WIDTH           = CIM_ACT_WIDTH,
    parameter int CIM_INPUT_PRECISION = cim_pkg::CIM_INPUT_PRECISION,
    parameter int ADC_PRECISION       = CIM_ADC_PRECISION,
    parameter int ACC_WIDTH           = CIM_ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ACT_WIDTH-1:0]           in_act0,
    input  logic [ACT_WIDTH-1:0]           in_act1,
    input  logic [ACT_WIDTH-1:0]           in_act2,
    input  logic [ACT_WIDTH-1:0]           in_act3,
    input  logic [2:0]                     in_rg,
    input  logic [1:0]                     in_col,
    output logic                           cim_cs,
    output logic                           cim_web,
    output logic                           cim_cimeb,
    output logic [ADDR_WIDTH-1:0]          cim_a,
    output logic [CIM_INPUT_PRECISION-1:0] cim_in0,
    output logic [CIM_INPUT_PRECISION-1:0] cim_in1,
    output logic [CIM_INPUT_PRECISION-1:0] cim_in2,
    output logic [CIM_INPUT_PRECISION-1:0] cim_in3,
    input  logic [ADC_PRECISION-1:0]       cim_res0,
    input  logic [ADC_PRECISION-1:0]       cim_res1,
    input  logic [ADC_PRECISION-1:0]       cim_res2,
    input  logic [ADC_PRECISION-1:0]       cim_res3,
    input  logic [ADC_PRECISION-1:0]       cim_res4,
    input  logic [ADC_PRECISION-1:0]       cim_res5,
    input  logic [ADC_PRECISION-1:0]       cim_res6,
    input  logic [ADC_PRECISION-1:0]       cim_res7,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH-1:0]           out_acc0,
    output logic [ACC_WIDTH-1:0]           out_acc1,
    output logic [ACC_WIDTH-1:0]           out_acc2,
    output logic [ACC_WIDTH-1:0]           out_acc3,
    output logic [ACC_WIDTH-1:0]           out_acc4,
    output logic [ACC_WIDTH-1:0]           out_acc5,
    output logic [ACC_WIDTH-1:0]           out_acc6,
    output logic [ACC_WIDTH-1:0]           out_acc7
);

    localparam int CIP    = CIM_INPUT_PRECISION;
    localparam int NSLICE = ACT_WIDTH / CIP;
    localparam int SLW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SHW    = $clog2(ACT_WIDTH) + 1;

    cim_state_t                   state_q;
    logic [SLW-1:0]               slice_q;
    logic [2:0]                   rg_q;
    logic [1:0]                   col_q;
    logic [ACT_WIDTH-1:0]         act_q    [CIM_NUM_ROWS];
    logic [ACT_WIDTH-1:0]         in_act   [CIM_NUM_ROWS];
    logic [ACT_WIDTH-1:0]         sel_act  [CIM_NUM_ROWS];
    logic [CIP-1:0]               cim_in_q [CIM_NUM_ROWS];
    logic [CIP-1:0]               iss_in   [CIM_NUM_ROWS];
    logic [ADC_PRECISION-1:0]     res_arr  [CIM_NUM_COLS];
    logic [ACC_WIDTH-1:0]         acc_arr  [CIM_NUM_COLS];
    logic [CIM_ADDR_WIDTH-1:0]    iss_a;
    logic                         accept;
    logic                         nxt_found;
    int                           nxt_idx;
    int                           start_idx;
    logic [SHW-1:0]               shamt;
`ifdef CIM_ZERO_SKIP_EN
    logic                         slice_nz;
`endif

    assign in_act[0] = in_act0;
    assign in_act[1] = in_act1;
    assign in_act[2] = in_act2;
    assign in_act[3] = in_act3;

    assign res_arr[0] = cim_res0;
    assign res_arr[1] = cim_res1;
    assign res_arr[2] = cim_res2;
    assign res_arr[3] = cim_res3;
    assign res_arr[4] = cim_res4;
    assign res_arr[5] = cim_res5;
    assign res_arr[6] = cim_res6;
    assign res_arr[7] = cim_res7;

    assign cim_in0 = cim_in_q[0];
    assign cim_in1 = cim_in_q[1];
    assign cim_in2 = cim_in_q[2];
    assign cim_in3 = cim_in_q[3];

    assign out_acc0 = acc_arr[0];
    assign out_acc1 = acc_arr[1];
    assign out_acc2 = acc_arr[2];
    assign out_acc3 = acc_arr[3];
    assign out_acc4 = acc_arr[4];
    assign out_acc5 = acc_arr[5];
    assign out_acc6 = acc_arr[6];
    assign out_acc7 = acc_arr[7];

    assign cim_web  = 1'b1;
    assign in_ready = (state_q == IDLE);
    assign accept   = in_ready && in_valid;
    assign shamt    = SHW'(int'(slice_q) * CIP);

    // Next-slice selection. From IDLE the decision is made on the incoming vector so the
    // first ISSUE (or the skip straight to DONE) happens on the acceptance edge.
    always_comb begin
        for (int r = 0; r < CIM_NUM_ROWS; r++) begin
            sel_act[r] = (state_q == IDLE) ? in_act[r] : act_q[r];
        end
        start_idx = (state_q == IDLE) ? 0 : int'(slice_q) + 1;
`ifdef CIM_ZERO_SKIP_EN
        nxt_found = 1'b0;
        nxt_idx   = 0;
        slice_nz  = 1'b0;
        // Scan downwards so the lowest qualifying slice wins.
        for (int s = NSLICE - 1; s >= 0; s--) begin
            slice_nz = 1'b0;
            for (int r = 0; r < CIM_NUM_ROWS; r++) begin
                slice_nz = slice_nz | (|sel_act[r][s*CIP +: CIP]);
            end
            if (s >= start_idx && slice_nz) begin
                nxt_found = 1'b1;
                nxt_idx   = s;
            end
        end
`else
        nxt_found = (start_idx < NSLICE);
        nxt_idx   = nxt_found ? start_idx : 0;
`endif
        for (int r = 0; r < CIM_NUM_ROWS; r++) begin
            iss_in[r] = sel_act[r][nxt_idx*CIP +: CIP];
        end
        iss_a = (state_q == IDLE) ? cim_addr(in_rg, in_col) : cim_addr(rg_q, col_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            slice_q   <= '0;
            rg_q      <= '0;
            col_q     <= '0;
            out_valid <= 1'b0;
            cim_cs    <= 1'b0;
            cim_cimeb <= 1'b1;
            cim_a     <= '0;
            for (int r = 0; r < CIM_NUM_ROWS; r++) begin
                act_q[r]    <= '0;
                cim_in_q[r] <= '0;
            end
        end else begin
            // Macro is idle in every state except ISSUE; entering ISSUE overrides below.
            cim_cs    <= 1'b0;
            cim_cimeb <= 1'b1;
            cim_a     <= '0;
            for (int r = 0; r < CIM_NUM_ROWS; r++) begin
                cim_in_q[r] <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int r = 0; r < CIM_NUM_ROWS; r++) begin
                            act_q[r] <= in_act[r];
                        end
                        rg_q  <= in_rg;
                        col_q <= in_col;
                    end
                end
                ISSUE:   state_q <= CAPTURE;
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: ;
            endcase
            // Shared launch path for IDLE-accept and CAPTURE-complete.
            if (accept || state_q == CAPTURE) begin
                if (nxt_found) begin
                    slice_q   <= SLW'(nxt_idx);
                    state_q   <= ISSUE;
                    cim_cs    <= 1'b1;
                    cim_cimeb <= 1'b0;
                    cim_a     <= ADDR_WIDTH'(iss_a);
                    for (int r = 0; r < CIM_NUM_ROWS; r++) begin
                        cim_in_q[r] <= iss_in[r];
                    end
                end else begin
                    if (accept) begin
                        slice_q <= '0;
                    end
                    state_q   <= DONE;
                    out_valid <= 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < CIM_NUM_COLS; c++) begin : g_col
        cim_col_acc #(
            .ADC_PRECISION (ADC_PRECISION),
            .ACC_WIDTH     (ACC_WIDTH),
            .SHW           (SHW)
        ) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (accept),
            .en    (state_q == CAPTURE),
            .shamt (shamt),
            .res   (res_arr[c]),
            .acc   (acc_arr[c])
        );
    end

endmodule

// File: tb/tb_cim_bitserial_ctrl.sv
// Directed bench for cim_bitserial_ctrl with a small CIM macro responder.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_cim_bitserial_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_act0, in_act1, in_act2, in_act3;
    logic [2:0]  in_rg;
    logic [1:0]  in_col;
    logic        cim_cs, cim_web, cim_cimeb;
    logic [9:0]  cim_a;
    logic [3:0]  cim_in0, cim_in1, cim_in2, cim_in3;
    logic [5:0]  res_drv;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_acc0, out_acc1, out_acc2, out_acc3, out_acc4, out_acc5, out_acc6, out_acc7;

    logic [5:0]  res_tab [2];
    int          issue_cnt;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    // Macro responder: samples a read at the ISSUE-ending edge and presents the result
    // for that transaction's n-th read during the following CAPTURE cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= 0;
            res_drv   <= '0;
        end else if (in_valid && in_ready) begin
            issue_cnt <= 0;
        end else if (cim_cs && !cim_cimeb) begin
            res_drv   <= res_tab[issue_cnt % 2];
            issue_cnt <= issue_cnt + 1;
        end
    end

    cim_bitserial_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act0   (in_act0),
        .in_act1   (in_act1),
        .in_act2   (in_act2),
        .in_act3   (in_act3),
        .in_rg     (in_rg),
        .in_col    (in_col),
        .cim_cs    (cim_cs),
        .cim_web   (cim_web),
        .cim_cimeb (cim_cimeb),
        .cim_a     (cim_a),
        .cim_in0   (cim_in0),
        .cim_in1   (cim_in1),
        .cim_in2   (cim_in2),
        .cim_in3   (cim_in3),
        .cim_res0  (res_drv),
        .cim_res1  (res_drv),
        .cim_res2  (res_drv),
        .cim_res3  (res_drv),
        .cim_res4  (res_drv),
        .cim_res5  (res_drv),
        .cim_res6  (res_drv),
        .cim_res7  (res_drv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc0  (out_acc0),
        .out_acc1  (out_acc1),
        .out_acc2  (out_acc2),
        .out_acc3  (out_acc3),
        .out_acc4  (out_acc4),
        .out_acc5  (out_acc5),
        .out_acc6  (out_acc6),
        .out_acc7  (out_acc7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acts(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3);
        in_act0 = a0;
        in_act1 = a1;
        in_act2 = a2;
        in_act3 = a3;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_rg      = 3'd0;
        in_col     = 2'd0;
        res_tab[0] = 6'd0;
        res_tab[1] = 6'd0;
        set_acts(8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cs", cim_cs, 0);
        chk("rst_web", cim_web, 1);
        chk("rst_cimeb", cim_cimeb, 1);
        chk("rst_a", cim_a, 0);
        chk("rst_in0", cim_in0, 0);
        chk("rst_acc0", out_acc0, 0);
        chk("rst_acc7", out_acc7, 0);
        rst = 1'b0;
        tick();

        // Basic two-slice transaction: results 5 then 7 -> 5 + 7*16 = 117
        set_acts(8'h23, 8'h23, 8'h23, 8'h41);
        in_rg      = 3'b101;
        in_col     = 2'b10;
        res_tab[0] = 6'd5;
        res_tab[1] = 6'd7;
        in_valid   = 1'b1;
        tick();                                  // E0 -> ISSUE slice 0
        in_valid = 1'b0;
        chk("t1_iss0_cs", cim_cs, 1);
        chk("t1_iss0_cimeb", cim_cimeb, 0);
        chk("t1_iss0_web", cim_web, 1);
        chk("t1_iss0_a", cim_a, 10'b00_101_000_10);
        chk("t1_iss0_in0", cim_in0, 3);
        chk("t1_iss0_in3", cim_in3, 1);
        chk("t1_iss0_in_ready", in_ready, 0);
        tick();                                  // E1 -> CAPTURE
        chk("t1_cap0_cs", cim_cs, 0);
        chk("t1_cap0_a", cim_a, 0);
        chk("t1_cap0_in0", cim_in0, 0);
        tick();                                  // E2 -> ISSUE slice 1
        chk("t1_iss1_cs", cim_cs, 1);
        chk("t1_iss1_a", cim_a, 10'b00_101_000_10);
        chk("t1_iss1_in0", cim_in0, 2);
        chk("t1_iss1_in3", cim_in3, 4);
        chk("t1_iss1_partial", out_acc0, 5);
        tick();                                  // E3 -> CAPTURE
        chk("t1_cap1_out_valid", out_valid, 0);
        tick();                                  // E4 -> DONE
        chk("t1_done_valid", out_valid, 1);
        chk("t1_done_acc0", out_acc0, 117);
        chk("t1_done_acc7", out_acc7, 117);
        chk("t1_done_web", cim_web, 1);

        // Back-pressure: result held, new vector waits
        set_acts(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        res_tab[0] = 6'd63;
        res_tab[1] = 6'd63;
        in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid_ready_cs", {out_valid, in_ready, cim_cs}, 3'b100);
            chk("bp_acc5", out_acc5, 117);
        end
        out_ready = 1'b1;
        tick();                                  // DONE -> IDLE, no accept yet
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_cs", cim_cs, 0);
        tick();                                  // accept 0xFF vector
        in_valid = 1'b0;
        chk("max_iss0_cs", cim_cs, 1);
        chk("max_iss0_in1", cim_in1, 15);
        repeat (4) tick();
        chk("max_done_valid", out_valid, 1);
        chk("max_done_acc0", out_acc0, 1071);
        chk("max_done_acc6", out_acc6, 1071);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-operation with a partial sum present
        set_acts(8'h23, 8'h23, 8'h23, 8'h23);
        in_rg      = 3'b010;
        in_col     = 2'b01;
        res_tab[0] = 6'd5;
        res_tab[1] = 6'd7;
        in_valid   = 1'b1;
        tick();                                  // ISSUE
        in_valid = 1'b0;
        tick();                                  // CAPTURE
        tick();                                  // ISSUE slice 1
        chk("mid_pre_cs", cim_cs, 1);
        chk("mid_pre_acc0", out_acc0, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", cim_cs, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_acc0", out_acc0, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_a", cim_a, 0);
        #2;
        rst = 1'b0;
        tick();

        // Fresh vector after reset: 10 + 3*16 = 58
        set_acts(8'h12, 8'h12, 8'h12, 8'h12);
        res_tab[0] = 6'd10;
        res_tab[1] = 6'd3;
        in_valid   = 1'b1;
        tick();                                  // ISSUE slice 0
        in_valid = 1'b0;
        chk("fresh_iss0_a", cim_a, 10'b00_010_000_01);
        chk("fresh_iss0_in0", cim_in0, 2);
        tick();
        tick();                                  // ISSUE slice 1
        chk("fresh_iss1_in2", cim_in2, 1);
        tick();
        chk("fresh_cap1_valid", out_valid, 0);
        tick();
        chk("fresh_done_valid", out_valid, 1);
        chk("fresh_done_acc0", out_acc0, 58);
        chk("fresh_done_acc4", out_acc4, 58);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef CIM_ZERO_SKIP_EN
        // Only slice 1 is non-zero: one ISSUE, done two edges after acceptance, 9 << 4 = 144
        set_acts(8'h30, 8'h30, 8'h30, 8'h30);
        res_tab[0] = 6'd9;
        res_tab[1] = 6'd9;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("zs_iss_cs", cim_cs, 1);
        chk("zs_iss_in0", cim_in0, 3);
        tick();
        chk("zs_cap_valid", out_valid, 0);
        tick();
        chk("zs_done_valid", out_valid, 1);
        chk("zs_done_acc0", out_acc0, 144);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // All-zero vector: done one edge after acceptance, no macro access
        set_acts(8'h00, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("zs0_valid", out_valid, 1);
        chk("zs0_cs", cim_cs, 0);
        chk("zs0_acc0", out_acc0, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
